// File: rtl/maxnet_engine.sv
// maxnet_engine: iterative winner-take-all (MAXNET) over N signed channels.
//
// Each iteration every activation is inhibited by epsilon times the sum of
// all other activations; the run ends when at most one activation stays
// positive or when MAX_ITER iterations have been executed.
//
// Handshake: start is a one-cycle request that is accepted only while the
// engine is idle (busy low). epsilon and data_in are captured on the
// accepting edge, so later changes to them have no effect on the run.
// Requests arriving while busy is high are dropped (there is no ready and
// no queueing). done pulses for exactly one cycle when found, timeout,
// winner_idx, max_val and iter_count have been updated; those outputs then
// hold until the next completed run.
//
// Optional build macro: MAXNET_TIE_BREAK_EN. When defined, a run that
// eliminates every channel reports the lowest index holding the largest
// original value as the winner instead of reporting "no winner".
//
// state_dbg exposes the FSM state for checkers and debug.

`timescale 1ns/1ps

module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 255,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    epsilon,
  input  logic [N*W-1:0]  data_in,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic            timeout,
  output logic [IW-1:0]   winner_idx,
  output logic [W-1:0]    max_val,
  output logic [15:0]     iter_count,
  output logic [2:0]      state_dbg
);

  // Sum width holds N activations without overflow; the product keeps the
  // full epsilon * difference width; one extra bit gives a sign for the
  // subtraction that follows.
  localparam int SW = W + IW;
  localparam int MW = W + SW;
  localparam int PW = MW + 1;
  localparam int CW = IW + 1;
  localparam logic signed [PW-1:0] MAX_POS = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ITER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [W-1:0]  eps_q;
  logic [W-1:0]  act      [N];
  logic [W-1:0]  orig     [N];
  logic [W-1:0]  next_act [N];
  logic [15:0]   iter_cnt;

  logic [SW-1:0] act_sum;
  logic [CW-1:0] pos_count;
  logic [IW-1:0] pos_idx;
  logic [W-1:0]  pos_val;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decision; CHECK picks between another iteration and the exit.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  next_state = S_CHECK;
      S_CHECK: begin
        if (pos_count <= CW'(1))                next_state = S_DONE;
        else if (iter_cnt == 16'(MAX_ITER))     next_state = S_DONE;
        else                                    next_state = S_ITER;
      end
      S_ITER:  next_state = S_CHECK;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Activation sum plus survivor count and the lowest surviving channel.
  always_comb begin
    act_sum   = '0;
    pos_count = '0;
    pos_idx   = '0;
    pos_val   = '0;
    for (int i = 0; i < N; i++) begin
      act_sum = act_sum + SW'(act[i]);
      if ($signed(act[i]) > 0) pos_count = pos_count + CW'(1);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if ($signed(act[i]) > 0) begin
        pos_idx = IW'(i);
        pos_val = orig[i];
      end
    end
  end

  // Per-channel inhibition lane: a' = a - floor(eps * (S - a) / 2^FRAC),
  // clamped into [0, 2^(W-1)-1]. All terms are non-negative, so the shift
  // is a floor as required.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [SW-1:0]        diff;
    logic [MW-1:0]        prod;
    logic [MW-1:0]        shifted;
    logic signed [PW-1:0] upd;

    assign diff     = act_sum - SW'(act[g]);
    assign prod     = MW'(eps_q) * MW'(diff);
    assign shifted  = prod >> FRAC;
    assign upd      = $signed({1'b0, MW'(act[g])}) - $signed({1'b0, shifted});
    assign next_act[g] = upd[PW-1]       ? '0 :
                         (upd > MAX_POS) ? MAX_POS[W-1:0] :
                                           upd[W-1:0];
  end

`ifdef MAXNET_TIE_BREAK_EN
  logic [IW-1:0] tie_idx;
  logic [W-1:0]  tie_val;

  // Lowest index holding the largest original (signed) value.
  always_comb begin
    tie_idx = '0;
    tie_val = orig[0];
    for (int i = 1; i < N; i++) begin
      if ($signed(orig[i]) > $signed(tie_val)) begin
        tie_idx = IW'(i);
        tie_val = orig[i];
      end
    end
  end
`endif

  // Datapath: capture on start, load activations, iterate, publish results.
  always_ff @(posedge clk) begin
    if (rst) begin
      eps_q      <= '0;
      iter_cnt   <= '0;
      done       <= 1'b0;
      found      <= 1'b0;
      timeout    <= 1'b0;
      winner_idx <= '0;
      max_val    <= '0;
      iter_count <= '0;
      for (int i = 0; i < N; i++) begin
        act[i]  <= '0;
        orig[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            eps_q <= epsilon;
            for (int i = 0; i < N; i++) orig[i] <= data_in[i*W +: W];
          end
        end
        S_LOAD: begin
          iter_cnt <= '0;
          for (int i = 0; i < N; i++) act[i] <= orig[i][W-1] ? '0 : orig[i];
        end
        S_ITER: begin
          iter_cnt <= iter_cnt + 16'd1;
          for (int i = 0; i < N; i++) act[i] <= next_act[i];
        end
        S_DONE: begin
          done       <= 1'b1;
          iter_count <= iter_cnt;
          if (pos_count == CW'(1)) begin
            found      <= 1'b1;
            timeout    <= 1'b0;
            winner_idx <= pos_idx;
            max_val    <= pos_val;
          end else if (pos_count == '0) begin
            timeout    <= 1'b0;
`ifdef MAXNET_TIE_BREAK_EN
            found      <= 1'b1;
            winner_idx <= tie_idx;
            max_val    <= tie_val;
`else
            found      <= 1'b0;
            winner_idx <= '0;
            max_val    <= '0;
`endif
          end else begin
            found      <= 1'b0;
            timeout    <= 1'b1;
            winner_idx <= '0;
            max_val    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_engine.sv
// tb_maxnet_engine: directed table, corner sequences and random runs for
// maxnet_engine (N=4, W=16, FRAC=8), with a second instance at MAX_ITER=3.

`timescale 1ns/1ps

module tb_maxnet_engine;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int FRAC = 8;
  localparam int CYCLE_LIMIT = 1000;

  typedef struct packed {
    logic        found;
    logic        timeout;
    logic [1:0]  idx;
    logic [15:0] val;
    logic [15:0] iter;
    logic [15:0] lat;
  } res_t;

  localparam int RW = $bits(res_t);

  typedef struct {
    logic [N*W-1:0] data;
    logic [W-1:0]   eps;
    res_t           exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start_a, start_b;
  logic [W-1:0]   epsilon;
  logic [N*W-1:0] data_in;

  logic        busy_a, done_a, found_a, timeout_a;
  logic [1:0]  idx_a;
  logic [15:0] val_a, iter_a;
  logic [2:0]  state_a;
  logic        busy_b, done_b, found_b, timeout_b;
  logic [1:0]  idx_b;
  logic [15:0] val_b, iter_b;
  logic [2:0]  state_b;

  maxnet_engine #(.N(N), .W(W), .FRAC(FRAC), .MAX_ITER(255)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .epsilon(epsilon), .data_in(data_in),
    .busy(busy_a), .done(done_a), .found(found_a), .timeout(timeout_a),
    .winner_idx(idx_a), .max_val(val_a), .iter_count(iter_a), .state_dbg(state_a)
  );

  maxnet_engine #(.N(N), .W(W), .FRAC(FRAC), .MAX_ITER(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .epsilon(epsilon), .data_in(data_in),
    .busy(busy_b), .done(done_b), .found(found_b), .timeout(timeout_b),
    .winner_idx(idx_b), .max_val(val_b), .iter_count(iter_b), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic res_t mk(input logic f, input logic t, input logic [1:0] idx,
                              input logic [15:0] val, input int it);
    res_t r;
    r.found   = f;
    r.timeout = t;
    r.idx     = idx;
    r.val     = val;
    r.iter    = 16'(it);
    r.lat     = 16'(3 + 2 * it);
    return r;
  endfunction

  // Reference: MAXNET recurrence on plain integers.
  function automatic res_t model(input logic [N*W-1:0] data, input logic [W-1:0] eps,
                                 input int max_iter);
    longint a[N];
    longint na[N];
    longint orig[N];
    longint s;
    longint maxpos;
    int p, k, w, best;
    res_t r;
    maxpos = (longint'(1) << (W - 1)) - 1;
    for (int i = 0; i < N; i++) begin
      orig[i] = longint'($signed(data[i*W +: W]));
      a[i]    = (orig[i] > 0) ? orig[i] : 0;
    end
    k = 0;
    r = '0;
    while (1) begin
      p = 0;
      w = 0;
      for (int i = N - 1; i >= 0; i--) if (a[i] > 0) begin p++; w = i; end
      if (p == 1) begin
        r.found = 1'b1;
        r.idx   = 2'(w);
        r.val   = 16'(orig[w]);
        break;
      end
      if (p == 0) begin
`ifdef MAXNET_TIE_BREAK_EN
        best = 0;
        for (int i = 1; i < N; i++) if (orig[i] > orig[best]) best = i;
        r.found = 1'b1;
        r.idx   = 2'(best);
        r.val   = 16'(orig[best]);
`else
        best = 0;
        r.found = 1'b0;
        r.idx   = 2'(best);
`endif
        break;
      end
      if (k == max_iter) begin
        r.timeout = 1'b1;
        break;
      end
      s = 0;
      for (int i = 0; i < N; i++) s += a[i];
      for (int i = 0; i < N; i++) begin
        na[i] = a[i] - ((longint'(eps) * (s - a[i])) / (longint'(1) << FRAC));
        if (na[i] < 0) na[i] = 0;
        if (na[i] > maxpos) na[i] = maxpos;
      end
      for (int i = 0; i < N; i++) a[i] = na[i];
      k++;
    end
    r.iter = 16'(k);
    r.lat  = 16'(3 + 2 * k);
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic run(input bit sel, input logic [N*W-1:0] d, input logic [W-1:0] e,
                     input bit disturb, output res_t got);
    int cyc;
    bit seen;
    @(negedge clk);
    data_in = d;
    epsilon = e;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < CYCLE_LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sel ? done_b : done_a) seen = 1'b1;
      else if (disturb && (cyc == 2 || cyc == 6)) begin
        start_a = 1'b1;
        data_in = {16'h0300, 16'h0001, 16'h0002, 16'h0003};
        epsilon = 16'h0001;
      end else begin
        start_a = 1'b0;
        data_in = {$urandom_range(0, 65535), $urandom_range(0, 65535),
                   $urandom_range(0, 65535), $urandom_range(0, 65535)};
        epsilon = 16'($urandom_range(0, 65535));
      end
    end
    start_a = 1'b0;
    got = '0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_wait: no done within %0d cycles", cyc);
    end else begin
      got.found   = sel ? found_b   : found_a;
      got.timeout = sel ? timeout_b : timeout_a;
      got.idx     = sel ? idx_b     : idx_a;
      got.val     = sel ? val_b     : val_a;
      got.iter    = sel ? iter_b    : iter_a;
      got.lat     = 16'(cyc);
      check("busy_at_done", sel ? busy_b : busy_a, 1'b0);
      @(posedge clk);
      #1;
      check("done_one_pulse", sel ? done_b : done_a, 1'b0);
    end
  endtask

  task automatic compare(input string tag, input res_t got, input res_t exp);
    check({tag, ".found"},   got.found,   exp.found);
    check({tag, ".timeout"}, got.timeout, exp.timeout);
    check({tag, ".idx"},     got.idx,     exp.idx);
    check({tag, ".val"},     got.val,     exp.val);
    check({tag, ".iter"},    got.iter,    exp.iter);
    check({tag, ".latency"}, got.lat,     exp.lat);
  endtask

  task automatic do_case(input string tag, input bit sel, input logic [N*W-1:0] d,
                         input logic [W-1:0] e, input bit disturb, input res_t exp);
    res_t got;
    exp_q.push_back(RW'(exp));
    run(sel, d, e, disturb, got);
    compare(tag, got, res_t'(exp_q.pop_front()));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".busy"},    busy_a,    1'b0);
    check({tag, ".done"},    done_a,    1'b0);
    check({tag, ".found"},   found_a,   1'b0);
    check({tag, ".timeout"}, timeout_a, 1'b0);
    check({tag, ".idx"},     idx_a,     2'd0);
    check({tag, ".val"},     val_a,     16'd0);
    check({tag, ".iter"},    iter_a,    16'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  localparam logic [N*W-1:0] V30 = {16'h0020, 16'h0040, 16'h0080, 16'h0100};

  initial begin
    vec_t tbl[8];
    res_t r30;
    logic [N*W-1:0] d;
    logic [W-1:0]   e;

    r30 = mk(1'b1, 1'b0, 2'd0, 16'h0100, 5);

    tbl[0] = '{V30, 16'h0020, r30};
    tbl[1] = '{{16'h0000, 16'h0000, 16'h0050, 16'hFF00}, 16'h0020,
               mk(1'b1, 1'b0, 2'd1, 16'h0050, 0)};
    tbl[4] = '{{16'h7FFF, 16'h0000, 16'h0000, 16'h0000}, 16'h0020,
               mk(1'b1, 1'b0, 2'd3, 16'h7FFF, 0)};
    tbl[5] = '{{16'h0100, 16'h0000, 16'h0200, 16'h0000}, 16'h0100,
               mk(1'b1, 1'b0, 2'd1, 16'h0200, 1)};
    tbl[6] = '{{16'h0000, 16'h0000, 16'h0100, 16'h0100}, 16'h0000,
               mk(1'b0, 1'b1, 2'd0, 16'h0000, 255)};
`ifdef MAXNET_TIE_BREAK_EN
    tbl[2] = '{{4{16'h0100}}, 16'h0080, mk(1'b1, 1'b0, 2'd0, 16'h0100, 1)};
    tbl[3] = '{{16'hFFFF, 16'h8000, 16'hFE00, 16'hFF00}, 16'h0020,
               mk(1'b1, 1'b0, 2'd3, 16'hFFFF, 0)};
    tbl[7] = '{{4{16'h7FFF}}, 16'hFFFF, mk(1'b1, 1'b0, 2'd0, 16'h7FFF, 1)};
`else
    tbl[2] = '{{4{16'h0100}}, 16'h0080, mk(1'b0, 1'b0, 2'd0, 16'h0000, 1)};
    tbl[3] = '{{16'hFFFF, 16'h8000, 16'hFE00, 16'hFF00}, 16'h0020,
               mk(1'b0, 1'b0, 2'd0, 16'h0000, 0)};
    tbl[7] = '{{4{16'h7FFF}}, 16'hFFFF, mk(1'b0, 1'b0, 2'd0, 16'h0000, 1)};
`endif

    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    epsilon = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    check("reset.busy_b", busy_b, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_case($sformatf("tbl%0d", i), 1'b0, tbl[i].data, tbl[i].eps, 1'b0, tbl[i].exp);
    end

    // Iteration limit on the MAX_ITER=3 instance.
    do_case("max_iter3", 1'b1, V30, 16'h0020, 1'b0, mk(1'b0, 1'b1, 2'd0, 16'h0000, 3));

    // Reset during the second ITER, then a clean rerun.
    @(negedge clk);
    data_in = V30;
    epsilon = 16'h0020;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrun.busy", busy_a, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    do_case("after_reset", 1'b0, V30, 16'h0020, 1'b0, r30);

    // start pulses with other data while busy must be ignored.
    do_case("start_while_busy", 1'b0, V30, 16'h0020, 1'b1, r30);

    // Random runs against the reference model.
    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 2) == 0) d[c*W +: W] = 16'($urandom_range(0, 65535));
        else                           d[c*W +: W] = 16'($urandom_range(0, 16'h0400));
      end
      if ($urandom_range(0, 3) == 0) d[W +: W] = d[0 +: W];
      e = 16'($urandom_range(1, 16'h0100));
      do_case($sformatf("rand_a%0d", i), 1'b0, d, e, 1'b0, model(d, e, 255));
    end
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < N; c++) d[c*W +: W] = 16'($urandom_range(0, 16'h0400));
      e = 16'($urandom_range(1, 16'h0040));
      do_case($sformatf("rand_b%0d", i), 1'b1, d, e, 1'b0, model(d, e, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maxnet_engine.md
MAXNET_ENGINE -- requirements
Module: maxnet_engine

Interface
REQ-001 Parameter N, default 4, number of competing channels (N >= 2).
REQ-002 Parameter W, default 16, data width, signed two's-complement fixed point.
REQ-003 Parameter FRAC, default 8, fractional bits of data and epsilon (FRAC < W).
REQ-004 Parameter MAX_ITER, default 255, iteration limit (1..2^16-1).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock, sole clock domain.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle request; sampled only in IDLE.
REQ-009 epsilon  input  W  unsigned Q.FRAC inhibition weight; sampled with start.
REQ-010 data_in  input  N*W  channel i at bits [i*W +: W]; sampled with start.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the result becomes valid.
REQ-013 found  output  1  single winner identified.
REQ-014 timeout  output  1  run ended at MAX_ITER with more than one survivor.
REQ-015 winner_idx  output  max(1,clog2(N))  index of winner.
REQ-016 max_val  output  W  original (loaded) input value of winner.
REQ-017 iter_count  output  16  iterations executed in the last run.

Function
REQ-018 FSM states IDLE, LOAD, CHECK, ITER, DONE; IDLE->LOAD on start; LOAD->CHECK; ITER->CHECK; DONE->IDLE unconditionally.
REQ-019 LOAD stores data_in in an original-value bank; activations a_i = max(data_in_i, 0); iteration counter cleared.
REQ-020 ITER computes, for all i in one cycle, a_i' = a_i - ((epsilon * (S - a_i)) >>> FRAC), with S = sum of all a_j at full width W+clog2(N), product at full width, arithmetic shift (floor).
REQ-021 a_i' negative -> 0; a_i' above 2^(W-1)-1 -> saturates to 2^(W-1)-1; iteration counter increments.
REQ-022 CHECK counts positive activations P: P==1 -> DONE, found=1; P==0 -> DONE, found=0 (tie path, see REQ-029); P>1 and count==MAX_ITER -> DONE, found=0, timeout=1; otherwise -> ITER.
REQ-023 On found=1: winner_idx = index of the positive activation, max_val = its original value.
REQ-024 On found=0: winner_idx=0, max_val=0.
REQ-025 Latency: done high exactly 3 + 2*k cycles after the start edge, k = iterations executed.
REQ-026 found, timeout, winner_idx, max_val, iter_count update in DONE and hold until the next LOAD.
REQ-027 start while busy is ignored; epsilon and data_in changes while busy have no effect.

Reset
REQ-028 rst, at any state including mid-run: next state IDLE; busy, done, found, timeout, winner_idx, max_val, iter_count, activations and original bank all 0.

Configuration
REQ-029 Macro MAXNET_TIE_BREAK_EN: when defined, the P==0 exit sets found=1, winner_idx = lowest index holding the largest original value, max_val = that value; when undefined, REQ-024 applies; timeout exit is unaffected either way.

Verification (N=4, W=16, FRAC=8)
REQ-030 data_in {0x0100,0x0080,0x0040,0x0020}, eps 0x0020 -> found=1, winner_idx=0, max_val=0x0100, iter_count=5, done 13 cycles after start.
REQ-031 data_in {0xFF00,0x0050,0,0}, eps 0x0020 -> found=1, winner_idx=1, max_val=0x0050, iter_count=0, done 3 cycles after start.
REQ-032 all inputs 0x0100, eps 0x0080 -> iter_count=1; without macro found=0, max_val=0; with macro found=1, winner_idx=0, max_val=0x0100.
REQ-033 MAX_ITER=3, REQ-030 vector -> found=0, timeout=1, iter_count=3, done 9 cycles after start.
REQ-034 rst asserted during the 2nd ITER of REQ-030 -> next cycle all outputs 0, busy=0; new start then reproduces REQ-030.
REQ-035 start pulsed while busy, with different data -> ignored; result identical to REQ-030.
